// File: rtl/dump_arbiter.sv
// Round-robin arbiter that shares one RAM-to-UART dump engine among four requesters.
// Each requester owns a fixed RAM region; one region is dumped per grant, guarded by a watchdog.
//
// state   | meaning
// S_IDLE  | no owner; waits for enable and a pending request
// S_GRANT | owner and region addresses latched, engine not yet started
// S_ISSUE | one-cycle send strobe to the engine, watchdog cleared
// S_WAIT  | engine running; waits for send_ok or watchdog expiry
// S_DONE  | completion pulse to the owner, pending bit cleared
module dump_arbiter #(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] REGION_LEN = 16'h0400,
  parameter logic [31:0]       TIMEOUT    = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic              enable,
  input  logic              send_ok,
  output logic              send_sig,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] end_addr,
  output logic [3:0]        grant,
  output logic [3:0]        pending,
  output logic              busy,
  output logic [3:0]        done,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        last;
  logic [1:0]        grant_idx;
  logic [1:0]        win_idx;
  logic [1:0]        cand;
  logic [31:0]       watchdog;
  logic              err_flag;
  logic [ADDR_W-1:0] start_calc;
  logic [ADDR_W-1:0] end_calc;
  logic [3:0]        clr_mask;

  // Reverse scan so the lowest offset from last+1 wins.
  always_comb begin
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (pending[cand]) win_idx = cand;
    end
  end

  assign start_calc = REGION_LEN * ADDR_W'(win_idx);
  assign end_calc   = start_calc + REGION_LEN - ADDR_W'(1);
  assign clr_mask   = (state == S_DONE) ? grant : 4'b0000;

  assign send_sig    = (state == S_ISSUE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE) ? grant : 4'b0000;
  assign timeout_err = (state == S_DONE) && err_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pending    <= 4'b0000;
      grant      <= 4'b0000;
      grant_idx  <= 2'd0;
      start_addr <= '0;
      end_addr   <= '0;
      watchdog   <= 32'd0;
      err_flag   <= 1'b0;
      last       <= 2'd3;
    end else begin
      // A request in the DONE cycle of the same requester survives the clear.
      pending <= (pending & ~clr_mask) | req;
      case (state)
        S_IDLE: begin
          // Owner and region are latched on entry to GRANT so the addresses
          // lead send_sig by one cycle.
          if (enable && (pending != 4'b0000)) begin
            state      <= S_GRANT;
            grant      <= 4'b0001 << win_idx;
            grant_idx  <= win_idx;
            start_addr <= start_calc;
            end_addr   <= end_calc;
          end
        end
        S_GRANT: begin
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          watchdog <= 32'd0;
          err_flag <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          watchdog <= watchdog + 32'd1;
          if (send_ok) begin
            state <= S_DONE;
          end else if (watchdog == TIMEOUT - 32'd1) begin
            err_flag <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          last  <= grant_idx;
          grant <= 4'b0000;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dump_arbiter.sv
// Bench for dump_arbiter: table-driven single transfers plus hand-written
// round-robin, timeout, enable, collision, reset and address-wrap sequences.
module tb_dump_arbiter;
  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic        enable;
  logic        send_ok;
  logic        send_sig;
  logic [15:0] start_addr, end_addr;
  logic [3:0]  grant, pending, done;
  logic        busy, timeout_err;

  logic [3:0]  req_b;
  logic        send_ok_b;
  logic        send_sig_b;
  logic [15:0] start_addr_b, end_addr_b;
  logic [3:0]  grant_b, pending_b, done_b;
  logic        busy_b, timeout_err_b;

  always #5 clk = ~clk;

  dump_arbiter #(.ADDR_W(16), .REGION_LEN(16'h0400), .TIMEOUT(32'd100)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .enable(enable), .send_ok(send_ok),
    .send_sig(send_sig), .start_addr(start_addr), .end_addr(end_addr),
    .grant(grant), .pending(pending), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  dump_arbiter #(.ADDR_W(16), .REGION_LEN(16'h8000), .TIMEOUT(32'd100)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .req(req_b), .enable(enable), .send_ok(send_ok_b),
    .send_sig(send_sig_b), .start_addr(start_addr_b), .end_addr(end_addr_b),
    .grant(grant_b), .pending(pending_b), .busy(busy_b), .done(done_b),
    .timeout_err(timeout_err_b)
  );

  typedef struct { logic [3:0] g; logic [15:0] s; logic [15:0] e; } sig_exp_t;
  typedef struct { logic [3:0] d; logic err; } done_exp_t;
  typedef struct { logic [3:0] req; int delay; logic [3:0] g; logic [15:0] s; logic [15:0] e; logic err; } vec_t;

  sig_exp_t  sig_q[$];
  done_exp_t done_q[$];
  int checks = 0;
  int errors = 0;
  int ok_delay = 10;
  int eng_cnt = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int k, input logic err);
    sig_q.push_back('{4'(1 << k), 16'(k * 32'h400), 16'(k * 32'h400 + 32'h3ff)});
    done_q.push_back('{4'(1 << k), err});
  endtask

  task automatic wait_sig(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!send_sig && cyc < 300);
    if (!send_sig) begin
      checks++; errors++;
      $display("FAIL %s: send_sig not seen within %0d cycles", name, cyc);
    end
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done == 4'b0000 && cyc < 400);
    if (done == 4'b0000) begin
      checks++; errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, cyc);
    end
  endtask

  // Dump engine model: answers send_sig with send_ok after ok_delay cycles (-1 = never).
  always @(negedge clk) begin
    send_ok = 1'b0;
    if (rst_n !== 1'b1) begin
      eng_cnt = -1;
    end else if (send_sig) begin
      eng_cnt = ok_delay;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        send_ok = 1'b1;
        eng_cnt = -1;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    sig_exp_t  se;
    done_exp_t de;
    if (rst_n === 1'b1) begin
      chk("grant_onehot", 32'($countones(grant)), busy ? 32'd1 : 32'd0);
      if (send_sig) begin
        if (sig_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_send_sig: got grant %b expected no transfer", grant);
        end else begin
          se = sig_q.pop_front();
          chk("sig_grant", 32'(grant), 32'(se.g));
          chk("sig_start", 32'(start_addr), 32'(se.s));
          chk("sig_end", 32'(end_addr), 32'(se.e));
        end
      end
      if (done != 4'b0000 || timeout_err) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done %b expected none", done);
        end else begin
          de = done_q.pop_front();
          chk("done_bits", 32'(done), 32'(de.d));
          chk("done_err", 32'(timeout_err), 32'(de.err));
        end
      end
    end
  end

  vec_t vecs[6];

  initial begin
    int cyc;
    vecs[0] = '{4'b0001, 3,   4'b0001, 16'h0000, 16'h03FF, 1'b0};
    vecs[1] = '{4'b1000, 1,   4'b1000, 16'h0C00, 16'h0FFF, 1'b0};
    vecs[2] = '{4'b0010, 7,   4'b0010, 16'h0400, 16'h07FF, 1'b0};
    vecs[3] = '{4'b0100, 99,  4'b0100, 16'h0800, 16'h0BFF, 1'b0};
    vecs[4] = '{4'b0100, 100, 4'b0100, 16'h0800, 16'h0BFF, 1'b0};
    vecs[5] = '{4'b0001, 150, 4'b0001, 16'h0000, 16'h03FF, 1'b1};

    rst_n = 1'b0; req = 4'b0; req_b = 4'b0; enable = 1'b1; send_ok_b = 1'b0;
    #1;
    chk("rst_send_sig", 32'(send_sig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_start", 32'(start_addr), 32'd0);
    chk("rst_end", 32'(end_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Address wrap on the REGION_LEN=0x8000 instance.
    req_b = 4'b1000;
    @(negedge clk); req_b = 4'b0000;
    chk("wrap_pending", 32'(pending_b), 32'h8);
    @(negedge clk);
    chk("wrap_grant", 32'(grant_b), 32'h8);
    chk("wrap_start", 32'(start_addr_b), 32'h8000);
    chk("wrap_end", 32'(end_addr_b), 32'hFFFF);
    @(negedge clk);
    chk("wrap_send_sig", 32'(send_sig_b), 32'd1);

    // Single request, cycle-exact.
    ok_delay = 10;
    push_exp(2, 1'b0);
    req = 4'b0100;
    @(negedge clk); req = 4'b0000;
    chk("single_pending", 32'(pending), 32'h4);
    chk("single_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_start_early", 32'(start_addr), 32'h0800);
    chk("single_end_early", 32'(end_addr), 32'h0BFF);
    chk("single_no_sig_yet", 32'(send_sig), 32'd0);
    @(negedge clk);
    chk("single_sig", 32'(send_sig), 32'd1);
    wait_done("single_done", cyc);
    chk("single_ok_latency", 32'(cyc), 32'd11);
    @(negedge clk);
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_pending0", 32'(pending), 32'd0);
    chk("single_done0", 32'(done), 32'd0);

    // Table of single transfers, including send_ok/timeout coincidence and late send_ok.
    for (int i = 0; i < 6; i++) begin
      ok_delay = vecs[i].delay;
      sig_q.push_back('{vecs[i].g, vecs[i].s, vecs[i].e});
      done_q.push_back('{vecs[i].g, vecs[i].err});
      req = vecs[i].req;
      @(negedge clk); req = 4'b0000;
      wait_sig("vec_sig", cyc);
      chk("vec_sig_latency", 32'(cyc), 32'd2);
      wait_done("vec_done", cyc);
      chk("vec_done_latency", 32'(cyc), vecs[i].err ? 32'(T + 1) : 32'(vecs[i].delay + 1));
      @(negedge clk);
      chk("vec_idle", 32'(busy), 32'd0);
    end
    repeat (60) @(negedge clk);
    chk("late_ok_ignored", 32'(busy), 32'd0);

    // Round robin: requester 1 busy, then 2, 3, 0.
    ok_delay = 5;
    push_exp(1, 1'b0); push_exp(2, 1'b0); push_exp(3, 1'b0); push_exp(0, 1'b0);
    req = 4'b0010;
    @(negedge clk); req = 4'b0000;
    wait_sig("rr_first_sig", cyc);
    req = 4'b1101;
    @(negedge clk); req = 4'b0000;
    for (int i = 0; i < 4; i++) wait_done("rr_done", cyc);
    @(negedge clk);
    chk("rr_pending0", 32'(pending), 32'd0);
    chk("rr_queue_empty", 32'(sig_q.size() + done_q.size()), 32'd0);

    // Watchdog timeout, then the next pending requester.
    ok_delay = -1;
    push_exp(1, 1'b1); push_exp(3, 1'b1);
    req = 4'b1010;
    @(negedge clk); req = 4'b0000;
    wait_sig("to_sig1", cyc);
    wait_done("to_done1", cyc);
    chk("to_latency1", 32'(cyc), 32'(T + 1));
    wait_sig("to_sig2", cyc);
    chk("to_gap", 32'(cyc), 32'd3);
    wait_done("to_done2", cyc);
    chk("to_latency2", 32'(cyc), 32'(T + 1));

    // Enable gating.
    ok_delay = 4;
    enable = 1'b0;
    req = 4'b0001;
    @(negedge clk); req = 4'b0000;
    repeat (5) @(negedge clk);
    chk("en_pending", 32'(pending), 32'h1);
    chk("en_busy", 32'(busy), 32'd0);
    push_exp(0, 1'b0);
    enable = 1'b1;
    wait_sig("en_sig", cyc);
    chk("en_sig_latency", 32'(cyc), 32'd2);
    wait_done("en_done", cyc);

    // Request in the DONE cycle of the same requester.
    ok_delay = 3;
    push_exp(2, 1'b0); push_exp(2, 1'b0);
    req = 4'b0100;
    @(negedge clk); req = 4'b0000;
    wait_sig("col_sig1", cyc);
    wait_done("col_done1", cyc);
    req = 4'b0100;
    @(negedge clk); req = 4'b0000;
    chk("col_pending_kept", 32'(pending), 32'h4);
    wait_sig("col_sig2", cyc);
    wait_done("col_done2", cyc);
    @(negedge clk);
    chk("col_pending0", 32'(pending), 32'd0);

    // Asynchronous reset mid-WAIT.
    ok_delay = -1;
    sig_q.push_back('{4'b1000, 16'h0C00, 16'h0FFF});
    req = 4'b1000;
    @(negedge clk); req = 4'b0000;
    wait_sig("rstw_sig", cyc);
    repeat (5) @(negedge clk);
    req = 4'b0010;
    @(negedge clk); req = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_grant", 32'(grant), 32'd0);
    chk("rstw_pending", 32'(pending), 32'd0);
    chk("rstw_send_sig", 32'(send_sig), 32'd0);
    chk("rstw_start", 32'(start_addr), 32'd0);
    chk("rstw_end", 32'(end_addr), 32'd0);
    chk("rstw_done", 32'(done | {3'b0, timeout_err}), 32'd0);
    sig_q.delete();
    done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstw_stay_idle", 32'(busy), 32'd0);
    chk("rstw_no_pending", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/dump_arbiter.md
# dump_arbiter

Round-robin scheduler that shares the single RAM-to-UART dump engine (32-bit word sender) among four requesters, typically the correlator channel result banks. Each requester owns a fixed, contiguous RAM region. The block latches dump requests and grants one requester at a time. For each grant it drives the engine's start/end addresses and one-cycle send strobe, then waits for the engine's completion pulse, with a watchdog timeout. It sits between the correlator control logic and the dump engine's `sendSig`/`startAddr`/`endAddr`/`ok` ports.

## Interface
- `ADDR_W`, 16: RAM word-address width. Must match the dump engine.
- `REGION_LEN`, 16'h0400: words per requester region. Region k spans k*REGION_LEN .. k*REGION_LEN+REGION_LEN-1.
- `TIMEOUT`, 32'd50_000_000: cycles allowed in WAIT before the transfer is abandoned (0.5 s at 100 MHz).
- `clk`  in  1  system clock, 100 MHz. All logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester dump request, sampled every cycle. Level or pulse; any high cycle sets that requester's pending bit.
- `enable`  in  1  when low, no new grant is issued. An in-flight transfer still completes.
- `send_ok`  in  1  completion pulse from the dump engine (one cycle).
- `send_sig`  out  1  one-cycle start strobe to the dump engine.
- `start_addr`  out  ADDR_W  first word address of the granted region.
- `end_addr`  out  ADDR_W  last word address of the granted region.
- `grant`  out  4  one-hot owner of the engine. Held from GRANT through DONE; zero otherwise.
- `pending`  out  4  latched, not-yet-served requests.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  4  one-cycle pulse on the served requester's bit, in DONE.
- `timeout_err`  out  1  one-cycle pulse in DONE when the transfer ended by watchdog.

## Operation
- Reset values: state=IDLE, pending=0, grant=0, start_addr=0, end_addr=0, send_sig=0, done=0, timeout_err=0, busy=0, watchdog=0, last=3 (so requester 0 has first priority).
- Pending bits: `pending[k]` is set by `req[k]` and cleared in DONE for the granted k. If set and clear coincide for the same bit, set wins and the region is dumped again later.
- FSM states and transitions:
  - IDLE: go to GRANT when `enable` is high and `pending` is nonzero.
  - GRANT: pick the first pending bit scanning from last+1 upward, mod 4. Register `grant`, `start_addr` and `end_addr`. Go to ISSUE.
  - ISSUE: `send_sig`=1. Clear the watchdog. Go to WAIT.
  - WAIT: increment the watchdog each cycle.
    - If `send_ok` is high, go to DONE with no error.
    - Otherwise, if watchdog == TIMEOUT-1, go to DONE with error.
    - `send_ok` takes priority when both occur in the same cycle.
  - DONE: pulse `done[k]`, and `timeout_err` if flagged. Clear `pending[k]`. Set last=k. Go to IDLE.
- Address arithmetic:
  - start = k*REGION_LEN, end = start+REGION_LEN-1, both truncated to ADDR_W bits (wrap modulo 2^ADDR_W).
  - Computed once, in GRANT.
  - `start_addr`/`end_addr` hold their values until the next GRANT. They do not return to 0 in IDLE.
- `send_ok` outside WAIT is ignored.
- `req` asserted for the granted requester during its transfer only re-sets pending; it never restarts the current transfer.
- `enable` deasserted during GRANT/ISSUE/WAIT has no effect on the current transfer.
- Watchdog: 32-bit counter. It does not wrap, because the FSM leaves WAIT at TIMEOUT-1.

## Timing
- All outputs come from registers or are decoded from the state register only; no combinational path from inputs to outputs.
- Start latency, with `req[k]` high at edge E0 and the engine idle:
  - `pending[k]` is high after E0.
  - GRANT is entered after E1.
  - ISSUE is entered after E2; `send_sig` is high for exactly the cycle E2–E3.
  - WAIT is entered after E3.
- `start_addr`/`end_addr` are stable from one cycle before `send_sig` rises until the next GRANT.
- Completion: `send_ok` sampled at edge Ek gives DONE after Ek, so `done`/`timeout_err` are high for the cycle Ek+1. IDLE is entered after Ek+1.
- Back-to-back service: the minimum gap from `done` to the next `send_sig` is 3 cycles (IDLE, GRANT, ISSUE).
- Reset mid-operation:
  - All state clears immediately, including pending requests, which are lost.
  - The dump engine shares `rst_n` and aborts as well.

## Test plan
- Single request: pulse `req`=4'b0100 with enable=1.
  - Expect `send_sig` 3 cycles later, start_addr=16'h0800, end_addr=16'h0BFF, grant=4'b0100.
  - Return `send_ok` 10 cycles later: done=4'b0100 for 1 cycle, `pending`=0, `busy` low 2 cycles after `send_ok`.
- Round robin: with the engine busy on requester 1, raise `req`=4'b1101.
  - Expect grants, in order, requester 2, then 3, then 0.
  - Each region is served exactly once, and `grant` is always one-hot.
- Timeout: run with TIMEOUT=100 and never assert `send_ok`.
  - Expect `timeout_err` and `done[k]` pulses 100 cycles after ISSUE, then the next pending requester is granted.
- Enable and collisions:
  - With enable=0, `req`=4'b0001: `pending`=4'b0001 and no `send_sig`. Raise enable: the grant follows 2 cycles later.
  - Assert `req[k]` in the DONE cycle of requester k: a second transfer of k occurs.
  - Assert `send_ok` in the same cycle the watchdog reaches TIMEOUT-1: no `timeout_err`.
- Reset mid-WAIT: assert rst_n=0 asynchronously.
  - All outputs are 0 immediately.
  - After release, no `send_sig` occurs without a new `req`.
  - REGION_LEN=16'h8000 with requester 3 gives start_addr=16'h8000 and end_addr=16'hFFFF, since 3*16'h8000 wraps modulo 2^16.
